register_bank_2r1w: RTL and testbench

- Parametrised successor to the single-port register bank of the rudimentary machine datapath.
- Provides one write port and two independent read ports (A, B), so the ALU can fetch both operands in one cycle.
- Adds synchronous reset, an optional hardwired-zero R0, optional registered reads, write-to-read bypass, and per-register "written since reset" valid tracking.
- Sits between the control unit (addresses, ld) and the ALU operand muxes.

---
 rtl/register_bank_2r1w_if.sv | 25 ++
 rtl/register_bank_2r1w.sv | 76 +++++++
 tb/tb_register_bank_2r1w.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/register_bank_2r1w_if.sv
// rtl/register_bank_2r1w_if.sv - write/read bus between control unit and register bank
interface register_bank_2r1w_if #(
  parameter int DW = 16,
  parameter int AW = 3
);
  logic          ld;
  logic [AW-1:0] addr_W;
  logic [DW-1:0] in;
  logic [AW-1:0] addr_A;
  logic [AW-1:0] addr_B;
  logic [DW-1:0] out_A;
  logic [DW-1:0] out_B;
  logic          valid_A;
  logic          valid_B;

  modport master (
    output ld, addr_W, in, addr_A, addr_B,
    input  out_A, out_B, valid_A, valid_B
  );

  modport slave (
    input  ld, addr_W, in, addr_A, addr_B,
    output out_A, out_B, valid_A, valid_B
  );
endinterface

// File: rtl/register_bank_2r1w.sv
// rtl/register_bank_2r1w.sv - parametrised 2-read 1-write register bank with valid tracking
module register_bank_2r1w #(
  parameter int DW       = 16,
  parameter int AW       = 3,
  parameter bit ZERO_R0  = 1'b1,
  parameter bit READ_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  register_bank_2r1w_if.slave bus
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] written;
  logic             write_en;
  logic [AW-1:0]    rd_addr  [2];
  logic [DW-1:0]    rd_data  [2];
  logic             rd_valid [2];

  // R0 stays 0 from reset onward because writes to it are suppressed here
  assign write_en   = bus.ld && !rst && !(ZERO_R0 && (bus.addr_W == '0));
  assign rd_addr[0] = bus.addr_A;
  assign rd_addr[1] = bus.addr_B;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      written <= DEPTH'(ZERO_R0);
    end else if (write_en) begin
      regs[bus.addr_W]    <= bus.in;
      written[bus.addr_W] <= 1'b1;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p]  = regs[rd_addr[p]];
      rd_valid[p] = written[rd_addr[p]];
      if (BYPASS && write_en && (bus.addr_W == rd_addr[p])) begin
        rd_data[p]  = bus.in;
        rd_valid[p] = 1'b1;
      end
    end
  end

  if (READ_REG) begin : g_reg
    logic [DW-1:0] out_q   [2];
    logic          valid_q [2];

    always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
        if (rst) begin
          out_q[p]   <= '0;
          valid_q[p] <= 1'b0;
        end else begin
          out_q[p]   <= rd_data[p];
          valid_q[p] <= rd_valid[p];
        end
      end
    end

    assign bus.out_A   = out_q[0];
    assign bus.out_B   = out_q[1];
    assign bus.valid_A = valid_q[0];
    assign bus.valid_B = valid_q[1];
  end else begin : g_comb
    assign bus.out_A   = rd_data[0];
    assign bus.out_B   = rd_data[1];
    assign bus.valid_A = rd_valid[0];
    assign bus.valid_B = rd_valid[1];
  end
endmodule

// File: tb/tb_register_bank_2r1w.sv
// tb/tb_register_bank_2r1w.sv - directed-vector bench for register_bank_2r1w
module tb_register_bank_2r1w;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // shared stimulus for the DW=16/AW=3 registered-read instances
  logic        s_ld;
  logic [2:0]  s_aw, s_aa, s_ab;
  logic [15:0] s_in;
  // shared stimulus for the DW=8/AW=4 combinational-read instances
  logic        c_ld;
  logic [3:0]  c_aw, c_aa, c_ab;
  logic [7:0]  c_in;

  register_bank_2r1w_if #(.DW(16), .AW(3)) b0 ();
  register_bank_2r1w_if #(.DW(16), .AW(3)) b1 ();
  register_bank_2r1w_if #(.DW(16), .AW(3)) b2 ();
  register_bank_2r1w_if #(.DW(8),  .AW(4)) b3 ();
  register_bank_2r1w_if #(.DW(8),  .AW(4)) b4 ();

  assign b0.ld = s_ld; assign b0.addr_W = s_aw; assign b0.in = s_in; assign b0.addr_A = s_aa; assign b0.addr_B = s_ab;
  assign b1.ld = s_ld; assign b1.addr_W = s_aw; assign b1.in = s_in; assign b1.addr_A = s_aa; assign b1.addr_B = s_ab;
  assign b2.ld = s_ld; assign b2.addr_W = s_aw; assign b2.in = s_in; assign b2.addr_A = s_aa; assign b2.addr_B = s_ab;
  assign b3.ld = c_ld; assign b3.addr_W = c_aw; assign b3.in = c_in; assign b3.addr_A = c_aa; assign b3.addr_B = c_ab;
  assign b4.ld = c_ld; assign b4.addr_W = c_aw; assign b4.in = c_in; assign b4.addr_A = c_aa; assign b4.addr_B = c_ab;

  register_bank_2r1w #(.DW(16), .AW(3), .ZERO_R0(1'b1), .READ_REG(1'b1), .BYPASS(1'b1))
    u_def  (.clk(clk), .rst(rst), .bus(b0.slave));
  register_bank_2r1w #(.DW(16), .AW(3), .ZERO_R0(1'b1), .READ_REG(1'b1), .BYPASS(1'b0))
    u_nobp (.clk(clk), .rst(rst), .bus(b1.slave));
  register_bank_2r1w #(.DW(16), .AW(3), .ZERO_R0(1'b0), .READ_REG(1'b1), .BYPASS(1'b1))
    u_noz  (.clk(clk), .rst(rst), .bus(b2.slave));
  register_bank_2r1w #(.DW(8),  .AW(4), .ZERO_R0(1'b1), .READ_REG(1'b0), .BYPASS(1'b1))
    u_comb (.clk(clk), .rst(rst), .bus(b3.slave));
  register_bank_2r1w #(.DW(8),  .AW(4), .ZERO_R0(1'b1), .READ_REG(1'b0), .BYPASS(1'b0))
    u_cnb  (.clk(clk), .rst(rst), .bus(b4.slave));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] cval(input int i);
    logic [3:0] hi, lo;
    hi = 4'(i);
    lo = 4'(15 - i);
    return {hi, lo};
  endfunction

  initial begin
    rst  = 1'b1;
    s_ld = 1'b0; s_aw = '0; s_in = '0; s_aa = '0; s_ab = '0;
    c_ld = 1'b0; c_aw = '0; c_in = '0; c_aa = '0; c_ab = '0;
    tick();
    tick();
    check("rst_out_A",   32'(b0.out_A), 32'h0);
    check("rst_valid_A", 32'(b0.valid_A), 32'h0);
    check("rst_out_B",   32'(b0.out_B), 32'h0);
    rst = 1'b0;

    for (int a = 0; a < 8; a++) begin
      s_aa = 3'(a);
      tick();
      check($sformatf("sweep_out_A[%0d]", a), 32'(b0.out_A), 32'h0);
      check($sformatf("sweep_valid_A[%0d]", a), 32'(b0.valid_A), (a == 0) ? 32'h1 : 32'h0);
    end
    s_aa = 3'd0;
    tick();
    check("noz_r0_valid_after_rst", 32'(b2.valid_A), 32'h0);

    // write R2 = 15, then read it back one edge after the address is presented
    s_ld = 1'b1; s_aw = 3'd2; s_in = 16'd15; s_aa = 3'd7;
    tick();
    s_ld = 1'b0; s_aa = 3'd2; s_ab = 3'd3;
    tick();
    check("wr_out_A",   32'(b0.out_A), 32'd15);
    check("wr_valid_A", 32'(b0.valid_A), 32'h1);
    check("wr_out_B",   32'(b0.out_B), 32'h0);
    check("wr_valid_B", 32'(b0.valid_B), 32'h0);

    s_ld = 1'b1; s_aw = 3'd5; s_in = 16'hABCD; s_aa = 3'd5;
    tick();
    check("bp_out_A",     32'(b0.out_A), 32'hABCD);
    check("bp_valid_A",   32'(b0.valid_A), 32'h1);
    check("nobp_out_A_0", 32'(b1.out_A), 32'h0);
    check("nobp_valid_0", 32'(b1.valid_A), 32'h0);
    s_ld = 1'b0;
    tick();
    check("nobp_out_A_1", 32'(b1.out_A), 32'hABCD);
    check("nobp_valid_1", 32'(b1.valid_A), 32'h1);

    s_ld = 1'b1; s_aw = 3'd0; s_in = 16'hFFFF; s_aa = 3'd0; s_ab = 3'd0;
    tick();
    s_ld = 1'b0;
    tick();
    check("r0_out_A",    32'(b0.out_A), 32'h0);
    check("r0_valid_A",  32'(b0.valid_A), 32'h1);
    check("r0_out_B",    32'(b0.out_B), 32'h0);
    check("r0_valid_B",  32'(b0.valid_B), 32'h1);
    check("noz_r0_out",  32'(b2.out_A), 32'hFFFF);
    check("noz_r0_val",  32'(b2.valid_A), 32'h1);

    s_ld = 1'b1; s_aw = 3'd1; s_in = 16'd7;
    tick();
    s_aw = 3'd6; s_in = 16'd9;
    tick();
    s_ld = 1'b0; s_aa = 3'd1; s_ab = 3'd6;
    tick();
    check("dual_out_A", 32'(b0.out_A), 32'd7);
    check("dual_out_B", 32'(b0.out_B), 32'd9);

    // reset wins over a same-cycle write
    rst = 1'b1; s_ld = 1'b1; s_aw = 3'd1; s_in = 16'd3;
    tick();
    check("rstp_out_A",   32'(b0.out_A), 32'h0);
    check("rstp_valid_A", 32'(b0.valid_A), 32'h0);
    rst = 1'b0; s_ld = 1'b0; s_aa = 3'd1; s_ab = 3'd6;
    tick();
    check("rstp_r1_out",   32'(b0.out_A), 32'h0);
    check("rstp_r1_valid", 32'(b0.valid_A), 32'h0);
    check("rstp_r6_out",   32'(b0.out_B), 32'h0);
    check("rstp_r6_valid", 32'(b0.valid_B), 32'h0);

    // combinational reads, DW=8 AW=4
    c_aa = 4'd9; c_ld = 1'b1; c_aw = 4'd9; c_in = 8'h5A;
    #1;
    check("comb_bp_out",    32'(b3.out_A), 32'h5A);
    check("comb_bp_valid",  32'(b3.valid_A), 32'h1);
    check("comb_nbp_out",   32'(b4.out_A), 32'h0);
    check("comb_nbp_valid", 32'(b4.valid_A), 32'h0);
    tick();
    c_ld = 1'b0;
    #1;
    check("comb_nbp_next_out",   32'(b4.out_A), 32'h5A);
    check("comb_nbp_next_valid", 32'(b4.valid_A), 32'h1);

    for (int i = 0; i < 16; i++) begin
      c_ld = 1'b1; c_aw = 4'(i); c_in = cval(i);
      tick();
    end
    c_ld = 1'b0;
    for (int i = 0; i < 16; i++) begin
      c_aa = 4'(i); c_ab = 4'(15 - i);
      #1;
      check($sformatf("comb_A[%0d]", i), 32'(b3.out_A), (i == 0) ? 32'h0 : 32'(cval(i)));
      check($sformatf("comb_vA[%0d]", i), 32'(b3.valid_A), 32'h1);
      check($sformatf("comb_B[%0d]", 15 - i), 32'(b3.out_B), (i == 15) ? 32'h0 : 32'(cval(15 - i)));
      check($sformatf("cnb_A[%0d]", i), 32'(b4.out_A), (i == 0) ? 32'h0 : 32'(cval(i)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
